uart_packet_tx: RTL and testbench

//   Serialises one 32-bit packet into four UART 8N1 frames (optional parity) on tx, MSB byte first.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_packet_tx_if.sv | 9 +
 rtl/uart_baud_tick.sv | 16 +
 rtl/uart_packet_tx.sv | 100 ++++++++++
 tb/tb_uart_packet_tx.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: speed encodings, tx FSM states and frame constants shared by the UART blocks
package uart_pkg;
  typedef enum logic [1:0] {SPD_9600, SPD_19200, SPD_57600, SPD_115200} speed_t;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
  localparam int DATA_BITS = 8;
  localparam int BYTES_PER_PKT = 4;
  function automatic logic [31:0] baud_div(input int clk_hz, input int baud);
    return 32'(clk_hz / baud);
  endfunction
endpackage

// File: rtl/uart_packet_tx_if.sv
// uart_packet_tx_if: packet handshake between the packet source and the serialiser
interface uart_packet_tx_if;
  logic [1:0] speed;
  logic [31:0] pkt_data;
  logic pkt_valid;
  logic pkt_ready;
  modport master (output speed, pkt_data, pkt_valid, input pkt_ready);
  modport slave (input speed, pkt_data, pkt_valid, output pkt_ready);
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable down-counter giving a one-cycle tick at the end of each bit period
module uart_baud_tick #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic [W-1:0] div,
  output logic         tick
);
  logic [W-1:0] cnt;
  assign tick = cnt == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= (clear || tick) ? div - 1'b1 : cnt - 1'b1;
endmodule

// File: rtl/uart_packet_tx.sv
// uart_packet_tx: sends a 32-bit packet as four UART frames, MSB byte first
module uart_packet_tx
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD0  = 9600,
  parameter int BAUD1  = 19200,
  parameter int BAUD2  = 57600,
  parameter int BAUD3  = 115200,
  parameter bit PARITY = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  uart_packet_tx_if.slave    pkt,
  output logic               tx,
  output logic               busy,
  output logic               done,
  output logic [1:0]         byte_idx
);
  localparam logic [31:0] DIV0 = baud_div(CLK_HZ, BAUD0);
  localparam logic [31:0] DIV1 = baud_div(CLK_HZ, BAUD1);
  localparam logic [31:0] DIV2 = baud_div(CLK_HZ, BAUD2);
  localparam logic [31:0] DIV3 = baud_div(CLK_HZ, BAUD3);
  state_t state;
  logic [31:0] sh, div_q, div_sel, div_in;
  logic [2:0] bit_cnt, nb;
  logic [1:0] byte_cnt;
  logic par, tick, accept, nbit;
  assign accept = state == ST_IDLE && pkt.pkt_valid;
  assign byte_idx = byte_cnt;
  always_comb begin
    div_sel = pkt.speed == SPD_115200 ? DIV3 : pkt.speed == SPD_57600 ? DIV2 :
              pkt.speed == SPD_19200 ? DIV1 : DIV0;
    div_in = accept ? div_sel : div_q;
    nb = bit_cnt + 3'd1;
    nbit = sh[{2'b11, nb}];
  end
  uart_baud_tick #(.W(32)) u_tick (.clk(clk), .reset(reset), .clear(accept), .div(div_in), .tick(tick));
  // the byte on the line always sits in sh[31:24]; bits are picked out LSB first
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      tx <= 1'b1;
      pkt.pkt_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      sh <= '0;
      div_q <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      par <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (pkt.pkt_valid) begin
          state <= ST_START;
          tx <= 1'b0;
          pkt.pkt_ready <= 1'b0;
          busy <= 1'b1;
          sh <= pkt.pkt_data;
          div_q <= div_sel;
          byte_cnt <= 2'(BYTES_PER_PKT - 1);
        end
        ST_START: if (tick) begin
          state <= ST_DATA;
          tx <= sh[24];
          par <= sh[24];
          bit_cnt <= '0;
        end
        ST_DATA: if (tick) begin
          if (bit_cnt == 3'(DATA_BITS - 1)) begin
            state <= PARITY ? ST_PARITY : ST_STOP;
            tx <= PARITY ? par : 1'b1;
          end else begin
            bit_cnt <= nb;
            tx <= nbit;
            par <= par ^ nbit;
          end
        end
        ST_PARITY: if (tick) begin
          state <= ST_STOP;
          tx <= 1'b1;
        end
        ST_STOP: if (tick) begin
          if (byte_cnt == 2'd0) begin
            state <= ST_IDLE;
            busy <= 1'b0;
            pkt.pkt_ready <= 1'b1;
            done <= 1'b1;
          end else begin
            state <= ST_START;
            tx <= 1'b0;
            byte_cnt <= byte_cnt - 2'd1;
            sh <= sh << 8;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_packet_tx.sv
// tb_uart_packet_tx: directed checks of the packet serialiser with a bit-sampling receive model
module tb_uart_packet_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  uart_packet_tx_if p0 ();
  uart_packet_tx_if p1 ();
  logic tx0, busy0, done0, tx1, busy1, done1;
  logic [1:0] bi0, bi1;
  uart_packet_tx #(.CLK_HZ(1_152_000), .PARITY(1'b0)) d0 (
    .clk(clk), .reset(reset), .pkt(p0), .tx(tx0), .busy(busy0), .done(done0), .byte_idx(bi0));
  uart_packet_tx #(.CLK_HZ(1_152_000), .PARITY(1'b1)) d1 (
    .clk(clk), .reset(reset), .pkt(p1), .tx(tx1), .busy(busy1), .done(done1), .byte_idx(bi1));
  int n_vec = 0, n_bad = 0, cyc = 0, dn0 = 0, dn1 = 0;
  logic sel = 1'b0;
  wire txm = sel ? tx1 : tx0;
  wire busym = sel ? busy1 : busy0;
  wire donem = sel ? done1 : done0;
  wire readym = sel ? p1.pkt_ready : p0.pkt_ready;
  wire [1:0] bim = sel ? bi1 : bi0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done0) dn0 <= dn0 + 1;
    if (done1) dn1 <= dn1 + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic send(input logic [31:0] d, input logic [1:0] spd);
    if (sel) begin
      p1.pkt_data = d; p1.speed = spd; p1.pkt_valid = 1'b1;
    end else begin
      p0.pkt_data = d; p0.speed = spd; p0.pkt_valid = 1'b1;
    end
    @(negedge clk);
    p0.pkt_valid = 1'b0;
    p1.pkt_valid = 1'b0;
  endtask
  // samples each bit in its middle; exact bit periods make any timing slip show as a bad bit
  task automatic rx_pkt(input int div, input logic [31:0] pkt, input string tag);
    int s = 0, t;
    logic [7:0] b, e;
    for (int k = 3; k >= 0; k--) begin
      e = pkt[k*8 +: 8];
      t = 0;
      while (txm !== 1'b0 && t < 4 * div) begin
        @(negedge clk);
        t++;
      end
      chk({tag, " start seen"}, 32'(txm), 32'd0);
      if (k == 3) s = cyc;
      repeat (div / 2) @(negedge clk);
      chk({tag, " start mid"}, 32'(txm), 32'd0);
      chk({tag, " byte_idx"}, 32'(bim), 32'(k));
      for (int i = 0; i < 8; i++) begin
        repeat (div) @(negedge clk);
        b[i] = txm;
      end
      chk({tag, " byte"}, 32'(b), 32'(e));
      if (sel) begin
        repeat (div) @(negedge clk);
        chk({tag, " parity"}, 32'(txm), 32'(^e));
      end
      repeat (div) @(negedge clk);
      chk({tag, " stop"}, 32'(txm), 32'd1);
    end
    t = 0;
    while (donem !== 1'b1 && t < div) begin
      @(negedge clk);
      t++;
    end
    chk({tag, " pkt time"}, 32'(cyc - s), 32'((sel ? 44 : 40) * div));
    chk({tag, " busy end"}, 32'(busym), 32'd0);
    chk({tag, " ready end"}, 32'(readym), 32'd1);
    chk({tag, " tx at done"}, 32'(txm), 32'd1);
    chk({tag, " idx end"}, 32'(bim), 32'd0);
    @(negedge clk);
    chk({tag, " done width"}, 32'(donem), 32'd0);
  endtask
  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d;
    p0.pkt_data = 32'hA53C_0F81; p0.speed = 2'b11; p0.pkt_valid = 1'b1;
    p1.pkt_data = 32'h0; p1.speed = 2'b00; p1.pkt_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst tx", 32'(tx0), 32'd1);
    chk("rst ready", 32'(p0.pkt_ready), 32'd1);
    chk("rst busy", 32'(busy0), 32'd0);
    chk("rst done", 32'(done0), 32'd0);
    chk("rst idx", 32'(bi0), 32'd0);
    chk("rst tx1", 32'(tx1), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("accept busy", 32'(busy0), 32'd1);
    chk("accept ready", 32'(p0.pkt_ready), 32'd0);
    chk("accept tx", 32'(tx0), 32'd0);
    p0.pkt_valid = 1'b0;
    rx_pkt(10, 32'hA53C_0F81, "t2");
    chk("t2 done count", 32'(dn0), 32'd1);
    send(32'h1234_5678, 2'b00);
    fork
      rx_pkt(120, 32'h1234_5678, "t3");
      begin
        repeat (50) @(negedge clk);
        p0.speed = 2'b11;
      end
    join
    p0.pkt_data = 32'h0; p0.speed = 2'b11; p0.pkt_valid = 1'b1;
    @(negedge clk);
    chk("t4 busy", 32'(busy0), 32'd1);
    p0.pkt_data = 32'hFFFF_FFFF;
    rx_pkt(10, 32'h0, "t4a");
    chk("t4 b2b start", 32'(tx0), 32'd0);
    chk("t4 b2b busy", 32'(busy0), 32'd1);
    p0.pkt_valid = 1'b0;
    rx_pkt(10, 32'hFFFF_FFFF, "t4b");
    sel = 1'b1;
    send(32'h0103_00FF, 2'b11);
    rx_pkt(10, 32'h0103_00FF, "t5");
    chk("t5 done count", 32'(dn1), 32'd1);
    sel = 1'b0;
    send(32'hDEAD_BEEF, 2'b11);
    d = 0;
    while (bi0 != 2'd2 && d < 200) begin
      @(negedge clk);
      d++;
    end
    chk("t6 reach byte2", 32'(bi0), 32'd2);
    repeat (15) @(negedge clk);
    d = dn0;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6 async tx", 32'(tx0), 32'd1);
    chk("t6 async busy", 32'(busy0), 32'd0);
    chk("t6 async ready", 32'(p0.pkt_ready), 32'd1);
    chk("t6 async idx", 32'(bi0), 32'd0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    chk("t6 no done", 32'(dn0), 32'(d));
    chk("t6 idle tx", 32'(tx0), 32'd1);
    send(32'h5A5A_C3C3, 2'b11);
    rx_pkt(10, 32'h5A5A_C3C3, "t6");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
